mii_tx_framer: RTL and testbench

- Per-port MII transmit stage. Drains one PHY-TX FIFO (byte plus end-of-frame delimiter, written by the control-frame issuer and the forwarding path) and drives the MII nibble interface.
- Generates preamble/SFD, serialises data low nibble first, appends the Ethernet FCS and enforces the inter-frame gap.
- One instance per PHY, clocked by that PHY's TX clock (the FIFO read side is in this domain).

---
 rtl/mii_tx_framer_pkg.sv | 25 ++
 rtl/mii_tx_framer_crc.sv | 18 +
 rtl/mii_tx_framer.sv | 188 ++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_tx_framer_pkg.sv
// mii_tx_framer_pkg: shared L2Switch state encoding, CRC-32 and MII framing constants.
package mii_tx_framer_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG,
    S_DROP
  } tx_state_e;
  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;
  localparam int MIN_FRAME_BYTES_DFLT = 60;
  // Reflected CRC-32 advanced by one nibble, bit 0 first.
  function automatic logic [31:0] crc32_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC32_POLY : 32'h0);
    return r;
  endfunction
endpackage

// File: rtl/mii_tx_framer_crc.sv
// crc32_nibble: registered reflected CRC-32 with synchronous init, advanced one nibble per enable.
module crc32_nibble
  import mii_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  din,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;
  always_comb crc_d = init ? CRC32_INIT : en ? crc32_nib(crc_q, din) : crc_q;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) crc_q <= CRC32_INIT;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: drains a byte FIFO onto MII with preamble/SFD, FCS, IFG and underrun handling.
// Optional MII_TX_PAD_EN pads short frames with zero bytes up to MIN_FRAME_BYTES.
module mii_tx_framer
  import mii_tx_framer_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24
`ifdef MII_TX_PAD_EN
  , parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DFLT
`endif
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_del,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  output logic [3:0]  mii_txd,
  output logic        mii_tx_en,
  output logic        mii_tx_er,
  output logic        tx_busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  underrun_cnt
);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES);
  // The idle cycle before the next preamble completes the gap on the wire.
  localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 2);
`ifdef MII_TX_PAD_EN
  localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);
`endif
  tx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [10:0] byte_cnt_q, byte_cnt_d, bc_inc;
  logic        und_q, und_d;
  logic        rd_pend_q, rd_pend_d;
  logic [3:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  underrun_cnt_q, underrun_cnt_d, und_sat;
  logic        crc_init, crc_en;
  logic [3:0]  crc_din;
  logic [31:0] crc, crc_sh;

  crc32_nibble u_crc (
    .clk   (clk),
    .arst_n(arst_n),
    .init  (crc_init),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  assign bc_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign und_sat = (&underrun_cnt_q) ? underrun_cnt_q : underrun_cnt_q + 8'd1;
  assign crc_sh = crc >> {cnt_q[2:0], 2'b00};
  assign rd_pend_d = fifo_rden;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    byte_cnt_d = byte_cnt_q;
    und_d = 1'b0;
    txd_d = 4'h0;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    fifo_rden = 1'b0;
    frame_cnt_d = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    crc_init = 1'b0;
    crc_en = 1'b0;
    crc_din = 4'h0;
    case (state_q)
      S_IDLE: begin
        crc_init = 1'b1;
        cnt_d = 8'd0;
        state_d = fifo_empty ? S_IDLE : S_PREAMBLE;
      end
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d = (cnt_q == PRE_LAST) ? SFD_NIB : PREAMBLE_NIB;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == PRE_LAST) begin
          phase_d = 1'b0;
          byte_cnt_d = 11'd0;
          fifo_rden = !fifo_empty;
          state_d = fifo_empty ? S_DROP : S_DATA;
          und_d = fifo_empty;
          underrun_cnt_d = fifo_empty ? und_sat : underrun_cnt_q;
        end
      end
      S_DATA: begin
        tx_en_d = 1'b1;
        txd_d = phase_q ? fifo_dout[7:4] : fifo_dout[3:0];
        crc_en = 1'b1;
        crc_din = txd_d;
        phase_d = !phase_q;
        if (phase_q) begin
          byte_cnt_d = bc_inc;
          cnt_d = 8'd0;
          if (fifo_del) begin
`ifdef MII_TX_PAD_EN
            state_d = (bc_inc < MIN_BYTES) ? S_PAD : S_FCS;
`else
            state_d = S_FCS;
`endif
          end else if (!fifo_empty) begin
            fifo_rden = 1'b1;
          end else begin
            state_d = S_DROP;
            und_d = 1'b1;
            underrun_cnt_d = und_sat;
          end
        end
      end
`ifdef MII_TX_PAD_EN
      S_PAD: begin
        tx_en_d = 1'b1;
        crc_en = 1'b1;
        phase_d = !phase_q;
        if (phase_q) begin
          byte_cnt_d = bc_inc;
          state_d = (bc_inc >= MIN_BYTES) ? S_FCS : S_PAD;
        end
      end
`endif
      S_FCS: begin
        tx_en_d = 1'b1;
        txd_d = ~crc_sh[3:0];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q[2:0] == 3'd7) begin
          state_d = S_IFG;
          cnt_d = 8'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_IFG: begin
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q >= IFG_LAST) ? S_IDLE : S_IFG;
      end
      S_DROP: begin
        // First cycle here carries the single error nibble; rd_pend_q marks fresh FIFO data.
        tx_en_d = und_q;
        tx_er_d = und_q;
        cnt_d = 8'd0;
        if (rd_pend_q && fifo_del) state_d = S_IFG;
        else fifo_rden = !fifo_empty;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q <= S_IDLE;
      cnt_q <= 8'd0;
      phase_q <= 1'b0;
      byte_cnt_q <= 11'd0;
      und_q <= 1'b0;
      rd_pend_q <= 1'b0;
      txd_q <= 4'h0;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      frame_cnt_q <= 16'd0;
      underrun_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      und_q <= und_d;
      rd_pend_q <= rd_pend_d;
      txd_q <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end

  assign mii_txd = txd_q;
  assign mii_tx_en = tx_en_q;
  assign mii_tx_er = tx_er_q;
  assign tx_busy = state_q != S_IDLE;
  assign frame_cnt = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: directed and random frames checked against a queue-based MII frame model.
module tb_mii_tx_framer;
  logic        clk;
  logic        arst_n;
  logic [7:0]  fifo_dout;
  logic        fifo_del;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [3:0]  mii_txd;
  logic        mii_tx_en;
  logic        mii_tx_er;
  logic        tx_busy;
  logic [15:0] frame_cnt;
  logic [7:0]  underrun_cnt;

  int total = 0;
  int bad = 0;
  logic [8:0] fq[$];
  logic [7:0] fr[$];
  logic [4:0] exp_nib[$];
  int         exp_len[$];
  logic       exp_res[$];
  logic [4:0] got_nib[$];
  int         burst_len[$];
  int         gaps[$];
  logic [4:0] cur[$];
  int  pops = 0;
  int  rd_count = 0;
  int  stall_at = 0;
  logic stall = 1'b0;
  int  fc_exp = 0;

  mii_tx_framer dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .fifo_dout   (fifo_dout),
    .fifo_del    (fifo_del),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .mii_txd     (mii_txd),
    .mii_tx_en   (mii_tx_en),
    .mii_tx_er   (mii_tx_er),
    .tx_busy     (tx_busy),
    .frame_cnt   (frame_cnt),
    .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) c = (c[0] ^ v[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // FIFO model: read data appears one cycle after the strobe.
  initial begin
    logic rd;
    forever begin
      @(negedge clk);
      rd = fifo_rden;
      if (rd) begin
        rd_count++;
        check("rden_while_empty", {31'h0, fifo_empty}, 0);
      end
      @(posedge clk);
      #1;
      if (rd && fq.size() != 0) begin
        {fifo_del, fifo_dout} = fq.pop_front();
        pops++;
      end
      fifo_empty = (fq.size() == 0) || (stall && pops >= stall_at);
    end
  end

  // MII collector: splits the wire into tx_en bursts and measures idle gaps between them.
  initial begin
    int idle;
    logic seen;
    idle = 0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        cur.delete();
        seen = 1'b0;
        idle = 0;
      end else if (mii_tx_en) begin
        if (cur.size() == 0 && seen) gaps.push_back(idle);
        cur.push_back({mii_tx_er, mii_txd});
      end else begin
        if (cur.size() != 0) begin
          foreach (cur[i]) got_nib.push_back(cur[i]);
          burst_len.push_back(cur.size());
          cur.delete();
          seen = 1'b1;
          idle = 0;
        end
        idle++;
      end
    end
  end

  // Queues fr into the FIFO and builds the expected wire image; und_at>=0 truncates at an underrun.
  task automatic send_frame(input int und_at);
    logic [7:0] p[$];
    logic [7:0] b;
    logic [31:0] c;
    int n, m;
    p = fr;
    foreach (fr[i]) fq.push_back({(i == fr.size() - 1) ? 1'b1 : 1'b0, fr[i]});
`ifdef MII_TX_PAD_EN
    if (und_at < 0) while (p.size() < 60) p.push_back(8'h00);
`endif
    for (int i = 0; i < 15; i++) exp_nib.push_back(5'h05);
    exp_nib.push_back(5'h0D);
    m = (und_at < 0) ? p.size() : und_at;
    n = 16 + 2 * m;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < m; i++) begin
      b = p[i];
      exp_nib.push_back({1'b0, b[3:0]});
      exp_nib.push_back({1'b0, b[7:4]});
      c = crc_bits(c, b, 8);
    end
    if (und_at < 0) begin
      c = ~c;
      for (int k = 0; k < 8; k++) exp_nib.push_back({1'b0, c[4*k +: 4]});
      n += 8;
    end else begin
      exp_nib.push_back(5'h10);
      n += 1;
    end
    exp_len.push_back(n);
    exp_res.push_back(und_at < 0);
  endtask

  task automatic wait_bursts(input int n);
    int k = 0;
    while (burst_len.size() < n && k < 20000) begin
      @(posedge clk);
      k++;
    end
    check("burst_timeout", {31'h0, burst_len.size() >= n}, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((tx_busy || fq.size() != 0) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check("idle_timeout", {31'h0, k < 5000}, 1);
  endtask

  task automatic cmp(input int n);
    for (int b = 0; b < n; b++) begin
      int l, el, mx;
      logic r;
      logic [31:0] c;
      logic [4:0] g, e;
      l = burst_len.pop_front();
      el = exp_len.pop_front();
      r = exp_res.pop_front();
      check("burst_len", l, el);
      mx = (l > el) ? l : el;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < mx; i++) begin
        g = 5'h1F;
        e = 5'h1F;
        if (i < l) g = got_nib.pop_front();
        if (i < el) e = exp_nib.pop_front();
        check("nibble", g, e);
        if (i >= 16 && i < l) c = crc_bits(c, {4'h0, g[3:0]}, 4);
      end
      if (r) check("fcs_residue", c, 32'hDEBB20E3);
    end
  endtask

  task automatic rand_frame(input int len);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
  endtask

  initial begin
    int rc0;
    arst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = 8'h00;
    fifo_del = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", {31'h0, mii_tx_en}, 0);
    check("rst_txd", {28'h0, mii_txd}, 0);
    check("rst_busy", {31'h0, tx_busy}, 0);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 0);
    #2 arst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_read", rd_count, 0);

    // 60-byte counting frame
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'(i));
    send_frame(-1);
    fc_exp++;
    wait_bursts(1);
    cmp(1);
    check("frame_cnt_1", {16'h0, frame_cnt}, fc_exp);
    wait_idle();

    // Back-to-back pair must see the full gap
    gaps.delete();
    rand_frame(20);
    send_frame(-1);
    rand_frame(30);
    send_frame(-1);
    fc_exp += 2;
    wait_bursts(2);
    cmp(2);
    check("gap_count", gaps.size(), 2);
    check("ifg_nibbles", gaps[1], 24);
    check("frame_cnt_pair", {16'h0, frame_cnt}, fc_exp);
    wait_idle();

    // Short frame: padded or not depending on build
    rand_frame(14);
    send_frame(-1);
    fc_exp++;
    wait_bursts(1);
    cmp(1);
    wait_idle();

    // Single-byte frame
    rc0 = rd_count;
    fr.delete();
    fr.push_back(8'hA5);
    send_frame(-1);
    fc_exp++;
    wait_bursts(1);
    cmp(1);
    wait_idle();
    check("single_rden", rd_count - rc0, 1);
    check("frame_cnt_single", {16'h0, frame_cnt}, fc_exp);

    // Underrun after 21 bytes of a 64-byte frame
    stall_at = pops + 21;
    stall = 1'b1;
    rand_frame(64);
    send_frame(21);
    wait_bursts(1);
    cmp(1);
    repeat (10) @(posedge clk);
    stall = 1'b0;
    wait_idle();
    check("drain_fifo", fq.size(), 0);
    check("drop_silent", burst_len.size(), 0);
    check("underrun_cnt", {24'h0, underrun_cnt}, 1);
    check("frame_cnt_after_und", {16'h0, frame_cnt}, fc_exp);
    rand_frame(10);
    send_frame(-1);
    fc_exp++;
    wait_bursts(1);
    cmp(1);
    check("frame_cnt_recover", {16'h0, frame_cnt}, fc_exp);
    wait_idle();

    // Random frames queued together
    for (int f = 0; f < 4; f++) begin
      rand_frame($urandom_range(1, 70));
      send_frame(-1);
      fc_exp++;
    end
    wait_bursts(4);
    cmp(4);
    check("frame_cnt_rand", {16'h0, frame_cnt}, fc_exp);
    wait_idle();

    // Reset mid-data
    rand_frame(60);
    send_frame(-1);
    begin
      int k = 0;
      while (!mii_tx_en && k < 200) begin
        @(posedge clk);
        k++;
      end
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("arst_tx_en", {31'h0, mii_tx_en}, 0);
    check("arst_txd", {28'h0, mii_txd}, 0);
    check("arst_tx_er", {31'h0, mii_tx_er}, 0);
    check("arst_busy", {31'h0, tx_busy}, 0);
    check("arst_rden", {31'h0, fifo_rden}, 0);
    check("arst_frame_cnt", {16'h0, frame_cnt}, 0);
    check("arst_underrun_cnt", {24'h0, underrun_cnt}, 0);
    fq.delete();
    exp_nib.delete();
    exp_len.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    #2 arst_n = 1'b1;
    got_nib.delete();
    burst_len.delete();
    fc_exp = 0;
    rc0 = rd_count;
    repeat (8) @(negedge clk);
    check("post_rst_busy", {31'h0, tx_busy}, 0);
    check("post_rst_no_read", rd_count - rc0, 0);
    rand_frame(5);
    send_frame(-1);
    fc_exp++;
    wait_bursts(1);
    cmp(1);
    check("frame_cnt_post_rst", {16'h0, frame_cnt}, fc_exp);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
